npc_ras_unit: RTL

Next-generation fetch-address unit for the tiny-CPU pipeline. It owns the PC register, computes the next PC (sequential, branch, jump, jump-register, return, exception), and handles stall and instruction-memory backpressure through a valid/ready handshake. It includes a parametrised return-address stack (RAS) for predicting `jr $ra` targets. It sits between the controller/ID stage, which supplies the NPC op and operands, and instruction memory.

---
 rtl/npc_ras_unit_pkg.sv | 19 +
 rtl/npc_ras_stack.sv | 68 ++++++
 rtl/npc_ras_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/npc_ras_unit_pkg.sv
// Shared NPC operation encodings, default reset/exception addresses and fetch FSM states.
package npc_ras_unit_pkg;

  localparam logic [2:0] NPC_PLUS4  = 3'd0;
  localparam logic [2:0] NPC_BRANCH = 3'd1;
  localparam logic [2:0] NPC_JUMP   = 3'd2;
  localparam logic [2:0] NPC_JR     = 3'd3;
  localparam logic [2:0] NPC_RET    = 3'd4;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHold
  } npc_state_e;

endpackage

// File: rtl/npc_ras_stack.sv
// Circular return-address LIFO with push, pop and replace-top; a push when full
// overwrites the oldest entry and sets the sticky ovf flag.
module npc_ras_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             replace,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             ovf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    top_q, top_d, wr_ptr;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d, wr_en, full;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign top   = mem_q[top_q];
  assign ovf   = ovf_q;

  always_comb begin
    top_d  = top_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    wr_en  = 1'b0;
    wr_ptr = top_q;
    // Replace on an empty stack has nothing to replace, so it becomes a push.
    if (push || (replace && empty)) begin
      wr_en  = 1'b1;
      wr_ptr = top_q + PW'(1);
      top_d  = wr_ptr;
      if (full) ovf_d = 1'b1;
      else      cnt_d = cnt_q + CW'(1);
    end else if (replace) begin
      wr_en = 1'b1;
    end else if (pop && !empty) begin
      top_d = top_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= din;
  end

endmodule

// File: rtl/npc_ras_unit.sv
// Fetch PC register, next-PC selection and return-address prediction with valid/ready fetch.
// Optional NPC_MISALIGN_EN: misaligned JR/RET register targets redirect to EXC_VEC, add misalign.
module npc_ras_unit
  import npc_ras_unit_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       npc_op,
  input  logic [25:0]      imm,
  input  logic [WIDTH-1:0] rs_data,
  input  logic             link,
  input  logic             exc,
  input  logic             stall,
  input  logic             req_ready,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic [WIDTH-1:0] npc,
  output logic             ras_empty,
  output logic             ras_ovf
`ifdef NPC_MISALIGN_EN
  ,
  output logic             misalign
`endif
);

  localparam logic [WIDTH-1:0] RstPc  = WIDTH'(RESET_PC);
  localparam logic [WIDTH-1:0] ExcVec = WIDTH'(EXC_VEC);

  npc_state_e       state_q, state_d;
  logic [WIDTH-1:0] pc_q, p4, br_off, jr_tgt, ras_top;
  logic             advance, ras_en, ras_push, ras_pop, ras_replace;
  logic             unused_rs_low;

  assign p4            = pc_q + WIDTH'(4);
  assign br_off        = {{(WIDTH - 18){imm[15]}}, imm[15:0], 2'b00};
  assign jr_tgt        = {rs_data[WIDTH-1:2], 2'b00};
  assign pc            = pc_q;
  assign unused_rs_low = ^rs_data[1:0];

  always_ff @(posedge clk) begin
    if (rst) state_q <= StBoot;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:        state_d = StRun;
      StRun, StHold: state_d = (exc || advance) ? StRun : StHold;
      default:       state_d = StBoot;
    endcase
  end

  always_comb begin
    pc_valid = (state_q != StBoot);
    advance  = pc_valid && req_ready && !stall;
  end

  always_comb begin
    npc = p4;
`ifdef NPC_MISALIGN_EN
    misalign = 1'b0;
`endif
    case (npc_op)
      NPC_BRANCH: npc = p4 + br_off;
      NPC_JUMP:   npc = {p4[WIDTH-1:28], imm, 2'b00};
      NPC_JR: begin
        npc = jr_tgt;
`ifdef NPC_MISALIGN_EN
        misalign = |rs_data[1:0];
`endif
      end
      NPC_RET: begin
        if (!ras_empty) begin
          npc = ras_top;
        end else begin
          npc = jr_tgt;
`ifdef NPC_MISALIGN_EN
          misalign = |rs_data[1:0];
`endif
        end
      end
      default:    npc = p4;
    endcase
`ifdef NPC_MISALIGN_EN
    if (misalign) npc = ExcVec;
`endif
    if (exc) npc = ExcVec;
  end

  // npc already carries EXC_VEC when exc is set, so one update path covers both.
  always_ff @(posedge clk) begin
    if (rst)                               pc_q <= RstPc;
    else if (pc_valid && (exc || advance)) pc_q <= npc;
  end

  assign ras_en      = advance && !exc;
  assign ras_push    = ras_en && link && (npc_op != NPC_RET);
  assign ras_pop     = ras_en && !link && (npc_op == NPC_RET);
  assign ras_replace = ras_en && link && (npc_op == NPC_RET);

  npc_ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst     (rst),
    .push    (ras_push),
    .pop     (ras_pop),
    .replace (ras_replace),
    .din     (p4),
    .top     (ras_top),
    .empty   (ras_empty),
    .ovf     (ras_ovf)
  );

endmodule
